// File: rtl/period_meter_pkg.sv
// ============================================================================
// Module      : period_meter_pkg
// Description : Shared state encoding and constants for the period meter.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package period_meter_pkg;

    typedef enum logic [0:0] {
        S_IDLE    = 1'b0,
        S_MEASURE = 1'b1
    } state_t;

    // Count value loaded on the cycle after any edge that starts a measurement
    localparam int unsigned c_count_reload = 1;

endpackage

`default_nettype wire

// File: rtl/period_log2_enc.sv
// ============================================================================
// Module      : period_log2_enc
// Description : Maps a measured period to the timer ceiling value whose
//               period matches: COUNTER_WIDTH - floor(log2(period-1)), clamped.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module period_log2_enc #(
    parameter int COUNTER_WIDTH = 25,
    parameter int CEILING_WIDTH = 4
) (
    input  logic [COUNTER_WIDTH:0]   i_period,
    output logic [CEILING_WIDTH-1:0] o_ceiling
);

    localparam int c_w   = COUNTER_WIDTH + 1;
    localparam int c_max = (1 << CEILING_WIDTH) - 1;

    logic [c_w-1:0] w_span;
    int             w_lg;
    int             w_diff;

    assign w_span = i_period - 1'b1;

    // Highest set bit of (period-1); a zero span is treated as log2 = 0
    always_comb begin
        w_lg = 0;
        for (int i = 0; i < c_w; i++) begin
            if (w_span[i]) begin
                w_lg = i;
            end
        end
        w_diff = COUNTER_WIDTH - w_lg;
        if (w_diff < 0) begin
            o_ceiling = '0;
        end else if (w_diff > c_max) begin
            o_ceiling = CEILING_WIDTH'(c_max);
        end else begin
            o_ceiling = CEILING_WIDTH'(w_diff);
        end
    end

endmodule

`default_nettype wire

// File: rtl/period_meter.sv
// ============================================================================
// Module      : period_meter
// Description : Measures clk_in cycles between rising edges of tick_in and
//               presents each result through a valid/ready register.
//               Macro PERIOD_METER_CEILING_EN enables the ceiling encoder;
//               without it ceiling_out is tied to zero.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module period_meter #(
    parameter int COUNTER_WIDTH = 25,
    parameter int CEILING_WIDTH = 4
) (
    input  logic                     clk_in,
    input  logic                     reset_in,
    input  logic                     tick_in,
    output logic [COUNTER_WIDTH:0]   period_out,
    output logic [CEILING_WIDTH-1:0] ceiling_out,
    output logic                     overflow_out,
    output logic                     valid_out,
    input  logic                     ready_in,
    output logic                     overrun_out
);

    import period_meter_pkg::*;

    localparam int c_w = COUNTER_WIDTH + 1;

    state_t                   r_state;
    state_t                   w_state_next;
    logic [c_w-1:0]           r_count;
    logic [c_w-1:0]           w_count_next;
    logic                     r_tick_prev;
    logic                     w_edge;
    logic                     w_done;
    logic                     w_done_ovf;
    logic [CEILING_WIDTH-1:0] w_ceiling;

    logic [c_w-1:0]           r_period;
    logic [CEILING_WIDTH-1:0] r_ceiling;
    logic                     r_overflow;
    logic                     r_valid;
    logic                     r_overrun;

    assign w_edge = tick_in & ~r_tick_prev;

    always_ff @(posedge clk_in) begin
        if (reset_in) begin
            r_state     <= S_IDLE;
            r_count     <= '0;
            r_tick_prev <= 1'b0;
        end else begin
            r_state     <= w_state_next;
            r_count     <= w_count_next;
            r_tick_prev <= tick_in;
        end
    end

    // An edge coinciding with saturation wins: it is a real period, not a timeout
    always_comb begin
        w_state_next = r_state;
        w_count_next = r_count;
        w_done       = 1'b0;
        w_done_ovf   = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (w_edge) begin
                    w_state_next = S_MEASURE;
                    w_count_next = c_w'(c_count_reload);
                end
            end
            S_MEASURE: begin
                if (w_edge) begin
                    w_done       = 1'b1;
                    w_count_next = c_w'(c_count_reload);
                end else if (&r_count) begin
                    w_done       = 1'b1;
                    w_done_ovf   = 1'b1;
                    w_state_next = S_IDLE;
                    w_count_next = '0;
                end else begin
                    w_count_next = r_count + 1'b1;
                end
            end
            default: begin
                w_state_next = S_IDLE;
                w_count_next = '0;
            end
        endcase
    end

`ifdef PERIOD_METER_CEILING_EN
    period_log2_enc #(
        .COUNTER_WIDTH (COUNTER_WIDTH),
        .CEILING_WIDTH (CEILING_WIDTH)
    ) u_log2_enc (
        .i_period  (r_count),
        .o_ceiling (w_ceiling)
    );
`else
    assign w_ceiling = '0;
`endif

    // A result completing against a stalled, still-full register is dropped
    always_ff @(posedge clk_in) begin
        if (reset_in) begin
            r_period   <= '0;
            r_ceiling  <= '0;
            r_overflow <= 1'b0;
            r_valid    <= 1'b0;
            r_overrun  <= 1'b0;
        end else begin
            r_overrun <= 1'b0;
            if (w_done && r_valid && !ready_in) begin
                r_overrun <= 1'b1;
            end else if (w_done) begin
                r_valid    <= 1'b1;
                r_period   <= r_count;
                r_overflow <= w_done_ovf;
                r_ceiling  <= w_done_ovf ? '0 : w_ceiling;
            end else if (r_valid && ready_in) begin
                r_valid <= 1'b0;
            end
        end
    end

    assign period_out   = r_period;
    assign ceiling_out  = r_ceiling;
    assign overflow_out = r_overflow;
    assign valid_out    = r_valid;
    assign overrun_out  = r_overrun;

endmodule

`default_nettype wire

// File: tb/tb_period_meter.sv
// ============================================================================
// Module      : tb_period_meter
// Description : Self-checking bench for period_meter (COUNTER_WIDTH=8,
//               CEILING_WIDTH=4); ceiling expectations follow
//               PERIOD_METER_CEILING_EN.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_period_meter;

    localparam int COUNTER_WIDTH = 8;
    localparam int CEILING_WIDTH = 4;
    localparam int c_maxp        = (1 << (COUNTER_WIDTH + 1)) - 1;

    logic                     clk_in;
    logic                     reset_in;
    logic                     tick_in;
    logic                     ready_in;
    logic [COUNTER_WIDTH:0]   period_out;
    logic [CEILING_WIDTH-1:0] ceiling_out;
    logic                     overflow_out;
    logic                     valid_out;
    logic                     overrun_out;

    int n_checks = 0;
    int n_fail   = 0;

    // Reference model state: edge timestamps rather than a counter
    bit m_armed;
    bit m_prev;
    int m_last;
    int m_cyc;
    bit e_valid;
    int e_period;
    bit e_ovf;
    int e_ceil;
    bit e_overrun;

    period_meter #(
        .COUNTER_WIDTH (COUNTER_WIDTH),
        .CEILING_WIDTH (CEILING_WIDTH)
    ) dut (
        .clk_in       (clk_in),
        .reset_in     (reset_in),
        .tick_in      (tick_in),
        .period_out   (period_out),
        .ceiling_out  (ceiling_out),
        .overflow_out (overflow_out),
        .valid_out    (valid_out),
        .ready_in     (ready_in),
        .overrun_out  (overrun_out)
    );

    initial begin
        clk_in = 1'b0;
        forever #5 clk_in = ~clk_in;
    end

    function automatic int exp_ceil(input int p);
        int v;
`ifdef PERIOD_METER_CEILING_EN
        v = COUNTER_WIDTH - ($clog2(p) - 1);
        if (v < 0) v = 0;
        if (v > (1 << CEILING_WIDTH) - 1) v = (1 << CEILING_WIDTH) - 1;
`else
        v = 0;
`endif
        return v;
    endfunction

    task automatic step(input logic t, input logic r);
        bit is_edge;
        bit done;
        bit ovfd;
        int p;
        int el;
        tick_in  = t;
        ready_in = r;
        if (reset_in) begin
            m_armed = 0; m_prev = 0; e_valid = 0; e_period = 0;
            e_ovf = 0; e_ceil = 0; e_overrun = 0;
        end else begin
            is_edge = t && !m_prev;
            done = 0; ovfd = 0; p = 0;
            if (m_armed) begin
                el = m_cyc - m_last;
                if (is_edge) begin
                    done = 1; p = el; m_last = m_cyc;
                end else if (el == c_maxp) begin
                    done = 1; ovfd = 1; p = c_maxp; m_armed = 0;
                end
            end else if (is_edge) begin
                m_armed = 1; m_last = m_cyc;
            end
            e_overrun = 0;
            if (done) begin
                if (e_valid && !r) begin
                    e_overrun = 1;
                end else begin
                    e_valid = 1; e_period = p; e_ovf = ovfd;
                    e_ceil = ovfd ? 0 : exp_ceil(p);
                end
            end else if (e_valid && r) begin
                e_valid = 0;
            end
            m_prev = t;
        end
        m_cyc++;
        @(posedge clk_in);
        #1;
    endtask

    task automatic do_reset();
        reset_in = 1'b1;
        step(1'b0, 1'b0);
        step(1'b0, 1'b0);
        reset_in = 1'b0;
    endtask

    task automatic test_reset();
        reset_in = 1'b1;
        step(1'b1, 1'b0);
        step(1'b1, 1'b0);
        n_checks++; if (valid_out !== 1'b0) begin n_fail++; $display("FAIL rst_valid got=%b exp=0", valid_out); end
        n_checks++; if (period_out !== '0) begin n_fail++; $display("FAIL rst_period got=%0d exp=0", period_out); end
        n_checks++; if (ceiling_out !== '0) begin n_fail++; $display("FAIL rst_ceiling got=%0d exp=0", ceiling_out); end
        n_checks++; if (overflow_out !== 1'b0) begin n_fail++; $display("FAIL rst_overflow got=%b exp=0", overflow_out); end
        n_checks++; if (overrun_out !== 1'b0) begin n_fail++; $display("FAIL rst_overrun got=%b exp=0", overrun_out); end
        reset_in = 1'b0;
        step(1'b1, 1'b1);
        step(1'b1, 1'b1);
        n_checks++; if (valid_out !== 1'b0) begin n_fail++; $display("FAIL rst_arm_valid got=%b exp=0", valid_out); end
    endtask

    task automatic test_periodic();
        do_reset();
        for (int k = 0; k < 6; k++) begin
            step(1'b1, 1'b1);
            if (k == 0) begin
                n_checks++; if (valid_out !== 1'b0) begin n_fail++; $display("FAIL per_first got=%b exp=0", valid_out); end
            end else begin
                n_checks++; if (valid_out !== 1'b1) begin n_fail++; $display("FAIL per_valid k=%0d got=%b exp=1", k, valid_out); end
                n_checks++; if (period_out !== 9'(17)) begin n_fail++; $display("FAIL per_period k=%0d got=%0d exp=17", k, period_out); end
                n_checks++; if (ceiling_out !== 4'(exp_ceil(17))) begin n_fail++; $display("FAIL per_ceiling k=%0d got=%0d exp=%0d", k, ceiling_out, exp_ceil(17)); end
                n_checks++; if (overflow_out !== 1'b0) begin n_fail++; $display("FAIL per_overflow k=%0d got=%b exp=0", k, overflow_out); end
            end
            for (int j = 0; j < 16; j++) begin
                step(1'b0, 1'b1);
                if (j == 0) begin
                    n_checks++; if (valid_out !== 1'b0) begin n_fail++; $display("FAIL per_one_cycle k=%0d got=%b exp=0", k, valid_out); end
                end
            end
        end
    endtask

    task automatic test_overflow();
        int n_res;
        int got_p;
        int got_c;
        bit got_o;
        do_reset();
        step(1'b1, 1'b1);
        n_res = 0; got_p = 0; got_c = 0; got_o = 0;
        for (int j = 0; j < 600; j++) begin
            step(1'b0, 1'b1);
            if (valid_out === 1'b1) begin
                n_res++; got_p = int'(period_out); got_c = int'(ceiling_out); got_o = overflow_out;
            end
        end
        n_checks++; if (n_res != 1) begin n_fail++; $display("FAIL ovf_count got=%0d exp=1", n_res); end
        n_checks++; if (got_p != c_maxp) begin n_fail++; $display("FAIL ovf_period got=%0d exp=%0d", got_p, c_maxp); end
        n_checks++; if (got_o !== 1'b1) begin n_fail++; $display("FAIL ovf_flag got=%b exp=1", got_o); end
        n_checks++; if (got_c != 0) begin n_fail++; $display("FAIL ovf_ceiling got=%0d exp=0", got_c); end
        step(1'b1, 1'b1);
        n_checks++; if (valid_out !== 1'b0) begin n_fail++; $display("FAIL ovf_rearm got=%b exp=0", valid_out); end
        n_res = 0;
        for (int j = 0; j < 510; j++) begin
            step(1'b0, 1'b1);
            if (valid_out === 1'b1) n_res++;
        end
        n_checks++; if (n_res != 0) begin n_fail++; $display("FAIL sat_early got=%0d exp=0", n_res); end
        step(1'b1, 1'b1);
        n_checks++; if (valid_out !== 1'b1) begin n_fail++; $display("FAIL sat_valid got=%b exp=1", valid_out); end
        n_checks++; if (period_out !== 9'(c_maxp)) begin n_fail++; $display("FAIL sat_period got=%0d exp=%0d", period_out, c_maxp); end
        n_checks++; if (overflow_out !== 1'b0) begin n_fail++; $display("FAIL sat_overflow got=%b exp=0", overflow_out); end
    endtask

    task automatic test_backpressure();
        int n_ovr;
        do_reset();
        step(1'b1, 1'b0);
        for (int j = 0; j < 4; j++) step(1'b0, 1'b0);
        step(1'b1, 1'b0);
        n_checks++; if (valid_out !== 1'b1 || period_out !== 9'(5)) begin n_fail++; $display("FAIL bp_first valid=%b period=%0d exp=1/5", valid_out, period_out); end
        n_ovr = 0;
        for (int k = 0; k < 3; k++) begin
            for (int j = 0; j < 4; j++) begin
                step(1'b0, 1'b0);
                if (overrun_out === 1'b1) n_ovr++;
            end
            step(1'b1, 1'b0);
            if (overrun_out === 1'b1) n_ovr++;
            n_checks++; if (overrun_out !== 1'b1) begin n_fail++; $display("FAIL bp_overrun k=%0d got=%b exp=1", k, overrun_out); end
            n_checks++; if (valid_out !== 1'b1 || period_out !== 9'(5)) begin n_fail++; $display("FAIL bp_hold k=%0d valid=%b period=%0d exp=1/5", k, valid_out, period_out); end
        end
        step(1'b0, 1'b0);
        if (overrun_out === 1'b1) n_ovr++;
        n_checks++; if (n_ovr != 3) begin n_fail++; $display("FAIL bp_pulses got=%0d exp=3", n_ovr); end
        step(1'b0, 1'b1);
        n_checks++; if (valid_out !== 1'b0) begin n_fail++; $display("FAIL bp_consume got=%b exp=0", valid_out); end
    endtask

    task automatic test_back_to_back();
        do_reset();
        step(1'b1, 1'b0);
        for (int j = 0; j < 4; j++) step(1'b0, 1'b0);
        step(1'b1, 1'b0);
        for (int j = 0; j < 6; j++) step(1'b0, 1'b0);
        n_checks++; if (valid_out !== 1'b1 || period_out !== 9'(5)) begin n_fail++; $display("FAIL b2b_held valid=%b period=%0d exp=1/5", valid_out, period_out); end
        step(1'b1, 1'b1);
        n_checks++; if (valid_out !== 1'b1) begin n_fail++; $display("FAIL b2b_valid got=%b exp=1", valid_out); end
        n_checks++; if (period_out !== 9'(7)) begin n_fail++; $display("FAIL b2b_period got=%0d exp=7", period_out); end
        n_checks++; if (overrun_out !== 1'b0) begin n_fail++; $display("FAIL b2b_overrun got=%b exp=0", overrun_out); end
        step(1'b0, 1'b1);
        n_checks++; if (valid_out !== 1'b0) begin n_fail++; $display("FAIL b2b_clear got=%b exp=0", valid_out); end
    endtask

    task automatic test_reset_mid();
        do_reset();
        step(1'b1, 1'b0);
        for (int j = 0; j < 4; j++) step(1'b0, 1'b0);
        step(1'b1, 1'b0);
        for (int j = 0; j < 8; j++) step(1'b0, 1'b0);
        reset_in = 1'b1;
        step(1'b0, 1'b0);
        reset_in = 1'b0;
        n_checks++; if (valid_out !== 1'b0) begin n_fail++; $display("FAIL mid_valid got=%b exp=0", valid_out); end
        step(1'b1, 1'b1);
        n_checks++; if (valid_out !== 1'b0) begin n_fail++; $display("FAIL mid_arm got=%b exp=0", valid_out); end
        for (int j = 0; j < 11; j++) step(1'b0, 1'b1);
        step(1'b1, 1'b1);
        n_checks++; if (valid_out !== 1'b1) begin n_fail++; $display("FAIL mid_result got=%b exp=1", valid_out); end
        n_checks++; if (period_out !== 9'(12)) begin n_fail++; $display("FAIL mid_period got=%0d exp=12", period_out); end
        n_checks++; if (ceiling_out !== 4'(exp_ceil(12))) begin n_fail++; $display("FAIL mid_ceiling got=%0d exp=%0d", ceiling_out, exp_ceil(12)); end
    endtask

    task automatic test_random();
        int  mode;
        int  len;
        logic t;
        logic r;
        do_reset();
        for (int seg = 0; seg < 12; seg++) begin
            mode = (seg == 1) ? 3 : int'($urandom_range(0, 3));
            len  = (mode == 3) ? 560 : 150;
            for (int c = 0; c < len; c++) begin
                case (mode)
                    0:       t = 1'($urandom_range(0, 1));
                    1:       t = ($urandom_range(0, 7) == 0);
                    2:       t = ($urandom_range(0, 39) == 0);
                    default: t = 1'b0;
                endcase
                r = ($urandom_range(0, 3) != 0);
                step(t, r);
                n_checks++;
                if (valid_out !== e_valid || overrun_out !== e_overrun) begin
                    n_fail++;
                    if (n_fail < 20) $display("FAIL rnd_flags cyc=%0d valid=%b overrun=%b exp=%b/%b", m_cyc, valid_out, overrun_out, e_valid, e_overrun);
                end
                if (e_valid) begin
                    n_checks++;
                    if (period_out !== 9'(e_period) || overflow_out !== e_ovf || ceiling_out !== 4'(e_ceil)) begin
                        n_fail++;
                        if (n_fail < 20) $display("FAIL rnd_result cyc=%0d period=%0d ovf=%b ceil=%0d exp=%0d/%b/%0d", m_cyc, period_out, overflow_out, ceiling_out, e_period, e_ovf, e_ceil);
                    end
                end
            end
        end
    endtask

    initial begin
        reset_in = 1'b1;
        tick_in  = 1'b0;
        ready_in = 1'b0;
        m_cyc    = 0;
        test_reset();
        test_periodic();
        test_overflow();
        test_backpressure();
        test_back_to_back();
        test_reset_mid();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule

`default_nettype wire
